// File: rtl/bram_dma_responder.sv
// Block-RAM stand-in for the DRAM side of the bsg_cache DMA interface.
// It services one packet at a time as a full cache-block burst of fill-width beats.
module bram_dma_responder #(
  parameter int caddr_width_p = 32,
  parameter int fill_width_p  = 64,
  parameter int block_width_p = 512,
  parameter int mem_els_p     = 4096
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [caddr_width_p:0]   dma_pkt_i,
  input  logic                     dma_pkt_v_i,
  output logic                     dma_pkt_yumi_o,
  output logic [fill_width_p-1:0]  dma_data_o,
  output logic                     dma_data_v_o,
  input  logic                     dma_data_ready_and_i,
  input  logic [fill_width_p-1:0]  dma_data_i,
  input  logic                     dma_data_v_i,
  output logic                     dma_data_yumi_o
);
  localparam int beats_lp = block_width_p / fill_width_p;
  localparam int off_lp   = $clog2(fill_width_p / 8);
  localparam int boff_lp  = $clog2(beats_lp);
  localparam int idx_lp   = $clog2(mem_els_p);
  localparam int cnt_w_lp = boff_lp + 1;
  localparam logic [cnt_w_lp-1:0] beats_c = cnt_w_lp'(beats_lp);
  localparam logic [cnt_w_lp-1:0] last_c  = cnt_w_lp'(beats_lp - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e                      state, state_n;
  logic [idx_lp-boff_lp-1:0]   blk;
  logic [cnt_w_lp-1:0]         issue_cnt, xfer_cnt, sel_cnt;
  logic                        vld_p1;
  logic [fill_width_p-1:0]     data_p1;
  logic [fill_width_p-1:0]     mem [mem_els_p];
  logic [idx_lp-1:0]           ram_addr;
  logic                        pkt_take, issue, xfer, wr;
  logic                        unused_bits;

  // Dropped address bits: upper bits alias, in-beat and in-block offsets are ignored.
  assign unused_bits = ^{dma_pkt_i[caddr_width_p-1:off_lp+idx_lp],
                         dma_pkt_i[off_lp+boff_lp-1:0], sel_cnt[boff_lp]};

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    pkt_take = 1'b0;
    issue    = 1'b0;
    xfer     = 1'b0;
    wr       = 1'b0;
    if (!reset_i) begin
      case (state)
        IDLE: begin
          pkt_take = dma_pkt_v_i;
          if (dma_pkt_v_i) state_n = dma_pkt_i[caddr_width_p] ? WRITE : READ;
        end
        READ: begin
          // Hold the RAM output while a beat is stalled so data stays stable.
          issue = (issue_cnt < beats_c) && (!vld_p1 || dma_data_ready_and_i);
          xfer  = vld_p1 && dma_data_ready_and_i;
          if (xfer && xfer_cnt == last_c) state_n = IDLE;
        end
        WRITE: begin
          wr = dma_data_v_i;
          if (wr && xfer_cnt == last_c) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      issue_cnt <= '0;
      xfer_cnt  <= '0;
      vld_p1    <= 1'b0;
    end else begin
      if (pkt_take) begin
        issue_cnt <= '0;
        xfer_cnt  <= '0;
      end else begin
        if (issue)      issue_cnt <= issue_cnt + cnt_w_lp'(1);
        if (xfer || wr) xfer_cnt  <= xfer_cnt + cnt_w_lp'(1);
      end
      if (issue)                     vld_p1 <= 1'b1;
      else if (dma_data_ready_and_i) vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pkt_take) blk <= dma_pkt_i[off_lp+boff_lp +: idx_lp-boff_lp];
  end

  assign sel_cnt  = (state == WRITE) ? xfer_cnt : issue_cnt;
  assign ram_addr = {blk, sel_cnt[boff_lp-1:0]};

  // ---- stage p0 -> p1: single-port RAM, one-cycle read latency
  always_ff @(posedge clk_i) begin
    if (wr)    mem[ram_addr] <= dma_data_i;
    if (issue) data_p1 <= mem[ram_addr];
  end

  assign dma_pkt_yumi_o  = pkt_take;
  assign dma_data_yumi_o = wr;
  assign dma_data_v_o    = vld_p1 && (state == READ);
  assign dma_data_o      = data_p1;
endmodule

// File: tb/tb_bram_dma_responder.sv
// Directed plus randomized bench for bram_dma_responder against a beat-array model.
module tb_bram_dma_responder;
  localparam int CW = 32;
  localparam int FW = 64;
  localparam int NB = 8;
  localparam int ME = 4096;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [CW:0]   dma_pkt_i;
  logic          dma_pkt_v_i;
  logic          dma_pkt_yumi_o;
  logic [FW-1:0] dma_data_o;
  logic          dma_data_v_o;
  logic          dma_data_ready_and_i;
  logic [FW-1:0] dma_data_i;
  logic          dma_data_v_i;
  logic          dma_data_yumi_o;

  int errors = 0;
  int checks = 0;
  logic [63:0] model_mem [ME];
  logic [63:0] vals [NB];
  logic [63:0] old_vals [NB];

  bram_dma_responder #(.caddr_width_p(CW), .fill_width_p(FW), .block_width_p(512),
                       .mem_els_p(ME)) dut (
    .clk_i(clk), .reset_i(reset_i), .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i),
    .dma_pkt_yumi_o(dma_pkt_yumi_o), .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o),
    .dma_data_ready_and_i(dma_data_ready_and_i), .dma_data_i(dma_data_i),
    .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o));

  always #5 clk = ~clk;

  function automatic int base_of(input logic [31:0] a);
    return ((a / 8) / NB * NB) % ME;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt(input bit wr, input logic [31:0] addr);
    dma_pkt_i   = {wr, addr};
    dma_pkt_v_i = 1'b1;
    #1;
    chk("pkt_yumi", dma_pkt_yumi_o, 1);
  endtask

  task automatic write_body(input int base, input int n, input bit gaps,
                            input bit nxt_v, input logic [CW:0] nxt_pkt);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < 200) begin
      step();
      cyc++;
      dma_pkt_v_i = nxt_v;
      dma_pkt_i   = nxt_pkt;
      if (gaps && ($urandom % 3 == 0)) begin
        dma_data_v_i = 1'b0;
        dma_data_i   = {$urandom, $urandom};
        #1;
        chk("wr_gap_yumi", dma_data_yumi_o, 0);
      end else begin
        dma_data_v_i = 1'b1;
        dma_data_i   = vals[i];
        #1;
        chk("wr_yumi", dma_data_yumi_o, 1);
        model_mem[base+i] = vals[i];
        i++;
      end
      chk("wr_pkt_yumi", dma_pkt_yumi_o, 0);
      chk("wr_data_v", dma_data_v_o, 0);
    end
    if (i < n) chk("wr_timeout", i, n);
    step();
    dma_data_v_i = 1'b0;
    #1;
  endtask

  task automatic read_body(input int base, input int mode,
                           input bit nxt_v, input logic [CW:0] nxt_pkt);
    int k = 0;
    int cyc = 0;
    bit stall = 0;
    logic [63:0] held = '0;
    while (k < NB && cyc < 200) begin
      step();
      cyc++;
      dma_pkt_v_i = nxt_v;
      dma_pkt_i   = nxt_pkt;
      case (mode)
        0:       dma_data_ready_and_i = 1'b1;
        1:       dma_data_ready_and_i = (cyc % 2 == 0);
        default: dma_data_ready_and_i = 1'($urandom % 2);
      endcase
      dma_data_v_i = 1'($urandom % 2);
      dma_data_i   = {$urandom, $urandom};
      #1;
      chk("rd_pkt_yumi", dma_pkt_yumi_o, 0);
      chk("rd_stray_yumi", dma_data_yumi_o, 0);
      if (cyc == 1) chk("rd_lat1", dma_data_v_o, 0);
      if (mode == 0 && cyc == 2) chk("rd_lat2", dma_data_v_o, 1);
      if (stall) begin
        chk("rd_hold_v", dma_data_v_o, 1);
        chk("rd_hold_data", dma_data_o, held);
      end
      stall = 0;
      if (dma_data_v_o) begin
        if (dma_data_ready_and_i) begin
          chk("rd_beat", dma_data_o, model_mem[base+k]);
          k++;
        end else begin
          stall = 1;
          held  = dma_data_o;
        end
      end
    end
    if (k < NB) chk("rd_timeout", k, NB);
    if (mode == 0) chk("rd_last_cycle", cyc, 9);
    step();
    dma_data_ready_and_i = 1'b1;
    dma_data_v_i = 1'b0;
    #1;
    chk("rd_done_v", dma_data_v_o, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input bit gaps);
    start_pkt(1'b1, addr);
    write_body(base_of(addr), NB, gaps, 1'b0, '0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int mode);
    start_pkt(1'b0, addr);
    read_body(base_of(addr), mode, 1'b0, '0);
  endtask

  initial begin
    logic [31:0] a, alias_a;
    reset_i = 1'b1;
    dma_pkt_i = '0;
    dma_pkt_v_i = 1'b1;
    dma_data_i = '0;
    dma_data_v_i = 1'b1;
    dma_data_ready_and_i = 1'b1;
    repeat (3) step();
    chk("rst_pkt_yumi", dma_pkt_yumi_o, 0);
    chk("rst_data_yumi", dma_data_yumi_o, 0);
    chk("rst_data_v", dma_data_v_o, 0);
    step();
    reset_i = 1'b0;
    dma_pkt_v_i = 1'b0;
    #1;
    chk("idle_pkt_yumi", dma_pkt_yumi_o, 0);
    chk("idle_stray_yumi", dma_data_yumi_o, 0);
    chk("idle_data_v", dma_data_v_o, 0);
    dma_data_v_i = 1'b0;

    // Write then read back, then backpressure and unaligned-address reads.
    for (int i = 0; i < NB; i++) vals[i] = 64'(8'h11 * (i + 1));
    do_write(32'h80, 1'b0);
    do_read(32'h80, 0);
    do_read(32'h80, 1);
    do_read(32'h93, 0);

    // Aliasing: block 0 is seen again one RAM-size higher.
    for (int i = 0; i < NB; i++) vals[i] = {$urandom, $urandom};
    do_write(32'h0, 1'b0);
    do_read(32'(ME * 8), 0);

    // Back-to-back: write with a read queued behind it, then read with a read queued.
    for (int i = 0; i < NB; i++) vals[i] = {$urandom, $urandom};
    start_pkt(1'b1, 32'h1C0);
    write_body(base_of(32'h1C0), NB, 1'b0, 1'b1, {1'b0, 32'h1C0});
    chk("b2b_wr_rd_yumi", dma_pkt_yumi_o, 1);
    read_body(base_of(32'h1C0), 0, 1'b1, {1'b0, 32'h80});
    chk("b2b_rd_rd_yumi", dma_pkt_yumi_o, 1);
    read_body(base_of(32'h80), 0, 1'b0, '0);

    // Reset after 3 of 8 write beats keeps those 3 and the 5 older beats.
    for (int i = 0; i < NB; i++) old_vals[i] = {$urandom, $urandom};
    vals = old_vals;
    do_write(32'h400, 1'b0);
    for (int i = 0; i < NB; i++) vals[i] = {$urandom, $urandom};
    start_pkt(1'b1, 32'h400);
    write_body(base_of(32'h400), 3, 1'b0, 1'b0, '0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    dma_data_v_i = 1'b1;
    #1;
    chk("post_rst_pkt_yumi", dma_pkt_yumi_o, 0);
    chk("post_rst_data_yumi", dma_data_yumi_o, 0);
    chk("post_rst_data_v", dma_data_v_o, 0);
    dma_data_v_i = 1'b0;
    do_read(32'h400, 2);

    // Randomized blocks, gapped writes, read back through an alias with random ready.
    for (int r = 0; r < 6; r++) begin
      a = $urandom;
      for (int i = 0; i < NB; i++) vals[i] = {$urandom, $urandom};
      do_write(a, 1'b1);
      alias_a = {a[31:6], 6'($urandom)} + 32'(($urandom % 4) * ME * 8);
      do_read(alias_a, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
